// File: rtl/pwm_multi_ctrl.sv
// pwm_multi_ctrl
//   Multi-channel PWM controller. NUM_CH channels share one period counter
//   that runs 0..PERIOD-1. Two push buttons, sampled through a shared
//   tick-driven debouncer, step the shadow duty of the channel picked by
//   ch_sel. Each channel's shadow duty is copied into its active duty only at
//   a period boundary, so an edit never produces a truncated or extra pulse.
//
//   Optional feature (macro PWM_PHASE_STAGGER_EN):
//     defined   - channel i runs on its own phase, (cnt + i*(PERIOD/NUM_CH))
//                 mod PERIOD. Its active duty reloads when that phase wraps,
//                 which spreads the output edges across the period.
//     undefined - every channel compares against cnt and is edge-aligned.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   ena           block enable; when low the counter and prescaler hold,
//                 pwm_out goes low and button presses are ignored
//   inc_btn       raw increase button
//   dec_btn       raw decrease button
//   ch_sel        channel targeted by the buttons (>= NUM_CH is ignored)
//   pwm_out       registered PWM outputs, one per channel
//   duty_sel      shadow duty of the selected channel (0 when out of range)
//   period_start  high for the one cycle in which cnt == 0
module pwm_multi_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 10,
  parameter int STEP      = 1,
  parameter int DUTY_INIT = 5,
  parameter int DEB_DIV   = 2,
  parameter int SEL_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              inc_btn,
  input  logic              dec_btn,
  input  logic [SEL_W-1:0]  ch_sel,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [CNT_W-1:0]  duty_sel,
  output logic              period_start
);

  localparam int              PW        = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX   = PW'(DEB_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W-1:0] STEP_N   = CNT_W'(STEP);
  // One extra bit keeps the saturation and phase arithmetic from wrapping
  // when PERIOD sits close to 2^CNT_W-1.
  localparam logic [CNT_W:0]  PERIOD_X  = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]  PHASE_MAX = (CNT_W+1)'(PERIOD - 1);
  localparam logic [CNT_W:0]  STEP_X    = (CNT_W+1)'(STEP);

  // ---------------------------------------------------------------------
  // Debounce sample tick
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          tick;
  logic          samp;

  always_comb begin
    tick = (DEB_DIV == 1) ? 1'b1 : (presc == PRE_MAX);
    samp = ena & tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ena) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Debouncer: two flops per button, loaded only on the sample tick.
  // A press is the tick on which the first flop has seen the button but
  // the second has not yet, so a long hold still yields a single press.
  // ---------------------------------------------------------------------
  logic inc_q1, inc_q2, dec_q1, dec_q2;
  logic inc_press, dec_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q1 <= 1'b0;
      inc_q2 <= 1'b0;
      dec_q1 <= 1'b0;
      dec_q2 <= 1'b0;
    end else if (samp) begin
      inc_q1 <= inc_btn;
      inc_q2 <= inc_q1;
      dec_q1 <= dec_btn;
      dec_q2 <= dec_q1;
    end
  end

  always_comb begin
    inc_press = samp & inc_q1 & ~inc_q2;
    dec_press = samp & dec_q1 & ~dec_q2;
  end

  // ---------------------------------------------------------------------
  // Shadow duty selection and saturating update
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] active [NUM_CH];
  logic [CNT_W-1:0] cur_duty;
  logic             sel_hit;
  logic [CNT_W:0]   inc_sum;
  logic [CNT_W-1:0] inc_val;
  logic [CNT_W-1:0] dec_val;
  logic [CNT_W-1:0] new_duty;
  logic             upd;

  always_comb begin
    cur_duty = '0;
    sel_hit  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == SEL_W'(i)) begin
        cur_duty = shadow[i];
        sel_hit  = 1'b1;
      end
    end
    inc_sum  = {1'b0, cur_duty} + STEP_X;
    inc_val  = (inc_sum > PERIOD_X) ? DUTY_MAX : inc_sum[CNT_W-1:0];
    dec_val  = ({1'b0, cur_duty} < STEP_X) ? '0 : cur_duty - STEP_N;
    // Both buttons in the same cycle cancel out.
    upd      = sel_hit & (inc_press ^ dec_press);
    new_duty = inc_press ? inc_val : dec_val;
    duty_sel = cur_duty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= DUTY_RST;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (upd && (ch_sel == SEL_W'(i))) shadow[i] <= new_duty;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Shared period counter
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic             wrap;

  always_comb wrap = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= ena & wrap;
      if (ena) cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel phase, compare and boundary detection
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] ph_wrap;
  logic [NUM_CH-1:0] ph_lt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef PWM_PHASE_STAGGER_EN
    localparam logic [CNT_W:0] OFF = (CNT_W+1)'(g * (PERIOD / NUM_CH));
`else
    localparam logic [CNT_W:0] OFF = '0;
`endif
    logic [CNT_W:0] ph_sum;
    logic [CNT_W:0] phase;

    // cnt < PERIOD and OFF < PERIOD, so one conditional subtract is a full mod.
    assign ph_sum     = {1'b0, cnt} + OFF;
    assign phase      = (ph_sum >= PERIOD_X) ? ph_sum - PERIOD_X : ph_sum;
    assign ph_wrap[g] = (phase == PHASE_MAX);
    assign ph_lt[g]   = (phase < {1'b0, active[g]});
  end

  // The reload uses the shadow value from before this edge, so a shadow write
  // landing on the boundary edge waits for the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) active[i] <= DUTY_RST;
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ena && ph_wrap[i]) active[i] <= shadow[i];
      end
      pwm_out <= ena ? ph_lt : '0;
    end
  end

endmodule
